// File: rtl/serial_sub_pkg.sv
// Shared FSM encodings and width helper for the bit-serial subtractor.
// Pure declarations: no latency, no flow control.
// Imported by serial_subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bit-counter width: must hold 0..W-1 with a spare bit of headroom
  function automatic int f_cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: D = A - B - B_in, borrow out on B_out.
// Combinational, zero latency; no flow control.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic B_in,
  output logic D,
  output logic B_out
);

  assign D     = A ^ B ^ B_in;
  assign B_out = (~A & B) | (~(A ^ B) & B_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor Diff = A - B, LSB first; optional Ovf via SERIAL_SUB_OVF_EN.
// Latency W cycles from the accepting edge; one op per W+1 cycles back-to-back.
// start is accepted only in IDLE/DONE; ignored while busy (no queueing).
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] Diff,
  output logic         B_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         Ovf
`endif
);

  localparam int CNT_W = f_cnt_w(W);

  state_t           state, state_nxt;
  logic [W-1:0]     sa, sb, res;
  logic             borrow;
  logic [CNT_W-1:0] cnt;
  logic             d, bo;
  logic             last_bit, accept;

  full_subtractor u_fs (
    .A    (sa[0]),
    .B    (sb[0]),
    .B_in (borrow),
    .D    (d),
    .B_out(bo)
  );

  assign last_bit = (cnt == CNT_W'(W - 1));
  assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign busy     = (state == ST_SHIFT);
  assign done     = (state == ST_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = start ? ST_SHIFT : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      Diff   <= '0;
      B_out  <= 1'b0;
    end else if (accept) begin
      sa     <= A;
      sb     <= B;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (busy) begin
      sa     <= {1'b0, sa[W-1:1]};
      sb     <= {1'b0, sb[W-1:1]};
      res    <= {d, res[W-1:1]};
      borrow <= bo;
      cnt    <= cnt + 1'b1;
      // Published outputs move only on the final bit so they stay stable across later ops
      if (last_bit) begin
        Diff  <= {d, res[W-1:1]};
        B_out <= bo;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // On the last shift sa[0]/sb[0] are the operand sign bits and d is the result sign
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                Ovf <= 1'b0;
    else if (busy && last_bit) Ovf <= (sa[0] != sb[0]) && (d != sa[0]);
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor against an arithmetic reference model.
// Build with +define+SERIAL_SUB_OVF_EN to also cover the overflow output.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A, B;
  logic         busy, done, B_out;
  logic [W-1:0] Diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         Ovf;
`endif

  int nvec = 0;
  int nerr = 0;

  logic [W-1:0] last_diff = '0;
  logic         last_bo   = 1'b0;
  logic         last_ovf  = 1'b0;

  always #5 clk = ~clk;

  serial_subtractor #(.W(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .A    (A),
    .B    (B),
    .busy (busy),
    .done (done),
    .Diff (Diff),
    .B_out(B_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .Ovf  (Ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] d, output logic bo, output logic ov);
    int ua, ub, sa, sb, sd;
    ua = int'(a);
    ub = int'(b);
    sa = a[W-1] ? ua - (1 << W) : ua;
    sb = b[W-1] ? ub - (1 << W) : ub;
    sd = sa - sb;
    d  = W'(ua - ub);
    bo = (ua < ub);
    ov = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
  endtask

  // Called away from a clock edge; leaves the bench 1ns after the completion edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit hold_start, input int glitch_at, input string tag);
    logic [W-1:0] ed;
    logic         eb, eo;
    model(a, b, ed, eb, eo);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    A = W'($urandom); B = W'($urandom);
    for (int k = 1; k <= W; k++) begin
      if (k == glitch_at) begin
        start = 1'b1; A = W'(1); B = W'(1);
      end else if (k == glitch_at + 1 && !hold_start) begin
        start = 1'b0;
      end
      if (k < W) begin
        check({tag, " busy"}, 32'(busy), 1);
        check({tag, " diff_hold"}, 32'(Diff), 32'(last_diff));
      end
      @(posedge clk); #1;
    end
    check({tag, " done"}, 32'(done), 1);
    check({tag, " busy_at_done"}, 32'(busy), 0);
    check({tag, " diff"}, 32'(Diff), 32'(ed));
    check({tag, " bout"}, 32'(B_out), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, " ovf"}, 32'(Ovf), 32'(eo));
`endif
    last_diff = ed;
    last_bo   = eb;
    last_ovf  = eo;
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    check({tag, " done_pulse"}, 32'(done), 0);
    check({tag, " idle_busy"}, 32'(busy), 0);
    check({tag, " idle_diff"}, 32'(Diff), 32'(last_diff));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst diff", 32'(Diff), 0);
    check("rst bout", 32'(B_out), 0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst ovf", 32'(Ovf), 0);
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'd100, 8'd37, 1'b0, 0, "t1");
    idle_check("t1");

    run_op(8'd5, 8'd9, 1'b0, 0, "t2a");
    idle_check("t2a");
    run_op(8'hFF, 8'hFF, 1'b0, 0, "t2b");
    idle_check("t2b");
    run_op(8'h00, 8'h01, 1'b0, 0, "t2c");
    idle_check("t2c");

    // Back-to-back: start stays high, new operands presented in the DONE cycle
    for (int i = 0; i < 4; i++) begin
      run_op(W'($urandom), W'($urandom), 1'b1, 0, "t3");
    end
    start = 1'b0;
    idle_check("t3");

    run_op(8'd200, 8'd55, 1'b0, 3, "t4");
    idle_check("t4");

    // Asynchronous reset in the middle of a shift
    A = 8'd100; B = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5 busy", 32'(busy), 0);
    check("t5 done", 32'(done), 0);
    check("t5 diff", 32'(Diff), 0);
    check("t5 bout", 32'(B_out), 0);
    @(negedge clk); rst_n = 1'b1;
    last_diff = '0; last_bo = 1'b0; last_ovf = 1'b0;
    @(posedge clk); #1;
    run_op(8'd20, 8'd7, 1'b0, 0, "t5");
    idle_check("t5");

`ifdef SERIAL_SUB_OVF_EN
    run_op(8'h80, 8'h01, 1'b0, 0, "t6a");
    run_op(8'h7F, 8'hFF, 1'b0, 0, "t6b");
    run_op(8'h03, 8'h05, 1'b0, 0, "t6c");
    idle_check("t6");
`endif

    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom), W'($urandom), 1'b0, 0, "rnd");
      if ($urandom_range(1, 0) == 1) idle_check("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
